dmem_mmio_bridge: RTL
=====================

# dmem_mmio_bridge

Sits between the processor's data-memory port and the dmem syncram; address-decodes every dmem access and routes it either to dmem or to a small bank of memory-mapped peripheral registers. The peripherals are an LED register, a free-running 32-bit timer with compare/match flag, and a 4-entry byte TX FIFO with a valid/ready output. MMIO reads return with the same 1-cycle latency as dmem, so the processor sees one uniform memory port.

## Interface
- No parameters; FIFO depth fixed at 4, address map fixed as below.
- clock  in  1  master clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- address_dmem  in  12  processor word address
- data  in  32  processor write data
- wren  in  1  processor write enable
- q_dmem  out  32  read data to processor
- mem_address  out  12  to dmem; equals address_dmem
- mem_data  out  32  to dmem; equals data
- mem_wren  out  1  to dmem; wren AND (address in dmem range)
- mem_q  in  32  read data from dmem
- led_out  out  32  LED register contents
- timer_irq  out  1  status bit0 (timer match sticky)
- tx_valid  out  1  FIFO non-empty
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  consumer accepts head this cycle

## Operation
- Address map: 0x000–0xEFF dmem; 0xF00 LED (RW); 0xF01 timer count (R; any write clears); 0xF02 timer compare (RW); 0xF03 status (R; write-1-to-clear bits 0 and 3); 0xF04 TX data (W: push data[7:0]; reads 0); 0xF05–0xFFF unmapped (reads 0, writes ignored).
- Status bits: [0] match sticky, [1] FIFO full, [2] FIFO empty, [3] overflow sticky; [31:4] read 0.
- Timer: count increments by 1 every cycle, wraps 0xFFFFFFFF→0. Write to 0xF01 loads 0 instead of incrementing (write wins). Match: when compare ≠ 0 and count == compare, set bit0. Set and W1C in the same cycle: set wins.
- FIFO: 4 entries, circular pointers with 3-bit occupancy count. Push on wren && address==0xF04. Pop on tx_valid && tx_ready. Push while full: accepted only if a pop occurs the same cycle; otherwise byte dropped, bit3 set. Push and pop on empty: push only (pop impossible since tx_valid=0).
- tx_data is the head entry combinationally; tx_valid = occupancy ≠ 0.
- mem_wren forced 0 for any address ≥ 0xF00; dmem never sees MMIO writes.

## Timing
- Read latency 1 cycle: address presented in cycle N → q_dmem valid in cycle N+1. Bridge registers a dmem/MMIO select bit and the MMIO read word at the edge ending cycle N; q_dmem = select ? mmio_reg : mem_q.
- MMIO read returns pre-edge value (count read in cycle N shows count of cycle N, not N+1).
- Writes take effect at the edge ending the cycle wren is high; readable the following cycle.
- Reset (reset=0 at an edge): led_out=0, count=0, compare=0, status sticky bits=0, FIFO empty (tx_valid=0), FIFO storage cleared (tx_data=0), select=dmem so q_dmem=mem_q, timer_irq=0. Reset mid-transaction discards in-flight FIFO data and pending read select; no write during reset cycle takes effect.
- mem_address, mem_data, mem_wren are combinational pass-through with no added latency.

## Test plan
- Reset then write 0xA5A5 to 0x010, read 0x010 → q_dmem=0x0000A5A5 one cycle after read address; mem_wren=1 only on write cycle.
- Write 0x0000000F to 0xF00 → led_out=0xF next cycle, mem_wren=0; read 0xF00 → q_dmem=0xF.
- Release reset, write compare=20 → timer_irq rises when count==20; write 0x1 to 0xF03 → timer_irq=0; write to 0xF01 → next read of 0xF01 returns small value (1 cycle later = 1).
- tx_ready=0, push 0x11,0x22,0x33,0x44,0x55 → status reads full=1, overflow=1; then tx_ready=1 → tx_data sequence 0x11,0x22,0x33,0x44, then tx_valid=0, empty=1.
- With FIFO full, push 0x66 in same cycle tx_ready=1 → 0x66 accepted, overflow unchanged.
- Assert reset with FIFO holding 2 bytes and led_out=0xF → next cycle tx_valid=0, led_out=0, reading 0xF01 after release returns small count.

Source files
------------

// File: rtl/dmem_mmio_bridge_if.sv
// dmem_mmio_bridge_if: processor port, dmem syncram port and TX byte stream of the bridge.
interface dmem_mmio_bridge_if;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic wren;
  logic [31:0] q_dmem;
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic mem_wren;
  logic [31:0] mem_q;
  logic tx_valid;
  logic [7:0] tx_data;
  logic tx_ready;
  modport master (
    output address_dmem, data, wren, mem_q, tx_ready,
    input q_dmem, mem_address, mem_data, mem_wren, tx_valid, tx_data
  );
  modport slave (
    input address_dmem, data, wren, mem_q, tx_ready,
    output q_dmem, mem_address, mem_data, mem_wren, tx_valid, tx_data
  );
endinterface

// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: routes dmem accesses to the syncram or to LED, timer and TX FIFO registers.
module dmem_mmio_bridge (
  input logic clock,
  input logic reset,
  dmem_mmio_bridge_if.slave bus,
  output logic [31:0] led_out,
  output logic timer_irq
);
  logic [31:0] count, compare, rdata, mmio_q;
  logic [7:0] fifo [4];
  logic [1:0] head, tail;
  logic [2:0] occ;
  logic sel, match_s, ovf_s, mmio, wr, w1c, push, pop, full, empty, accept;
  logic [11:0] addr;
  assign addr = bus.address_dmem;
  assign mmio = addr[11:8] == 4'hF;
  assign wr = bus.wren & mmio;
  assign w1c = wr & (addr == 12'hF03);
  assign bus.mem_address = addr;
  assign bus.mem_data = bus.data;
  assign bus.mem_wren = bus.wren & ~mmio;
  assign full = occ == 3'd4;
  assign empty = occ == 3'd0;
  assign push = wr & (addr == 12'hF04);
  assign pop = bus.tx_valid & bus.tx_ready;
  // a full FIFO still takes the byte when the head leaves in the same cycle
  assign accept = push & (~full | pop);
  assign bus.tx_valid = ~empty;
  assign bus.tx_data = fifo[head];
  assign bus.q_dmem = sel ? mmio_q : bus.mem_q;
  assign timer_irq = match_s;
  always_comb
    rdata = addr == 12'hF00 ? led_out :
            addr == 12'hF01 ? count :
            addr == 12'hF02 ? compare :
            addr == 12'hF03 ? {28'd0, ovf_s, empty, full, match_s} : 32'd0;
  always_ff @(posedge clock)
    if (!reset) begin
      led_out <= '0;
      count <= '0;
      compare <= '0;
      match_s <= 1'b0;
      ovf_s <= 1'b0;
      fifo <= '{default: 8'd0};
      head <= '0;
      tail <= '0;
      occ <= '0;
      sel <= 1'b0;
      mmio_q <= '0;
    end else begin
      sel <= mmio;
      mmio_q <= rdata;
      count <= (wr && addr == 12'hF01) ? 32'd0 : count + 32'd1;
      if (wr && addr == 12'hF00) led_out <= bus.data;
      if (wr && addr == 12'hF02) compare <= bus.data;
      match_s <= (compare != 32'd0 && count == compare) | (match_s & ~(w1c & bus.data[0]));
      ovf_s <= (push & ~accept) | (ovf_s & ~(w1c & bus.data[3]));
      if (accept) begin
        fifo[tail] <= bus.data[7:0];
        tail <= tail + 2'd1;
      end
      if (pop) head <= head + 2'd1;
      occ <= occ + {2'b0, accept} - {2'b0, pop};
    end
endmodule
